// File: rtl/regfile_sb_pkg.sv
// Shared register-file definitions: default geometry, address/counter width
// derivation and slice helpers for packed multi-port buses.
package rf_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;

  function automatic int addr_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  function automatic int cnt_w(input int nreg);
    return $clog2(nreg + 1);
  endfunction

  // LSB of field 'port' in a packed bus of 'width'-bit fields
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bundle of the register file: read ports, writeback,
// issue strobe, flush and busy count.
interface regfile_sb_if #(
  parameter int XLEN = rf_pkg::XLEN_DEF,
  parameter int NREG = rf_pkg::NREG_DEF,
  parameter int NRD  = rf_pkg::NRD_DEF
);
  localparam int AW = rf_pkg::addr_w(NREG);
  localparam int CW = rf_pkg::cnt_w(NREG);

  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rbusy;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic                iss;
  logic [AW-1:0]       ia;
  logic                flush;
  logic [CW-1:0]       nbusy;

  modport master (
    output ra, we, wa, wd, iss, ia, flush,
    input  rd, rbusy, nbusy
  );

  modport slave (
    input  ra, we, wa, wd, iss, ia, flush,
    output rd, rbusy, nbusy
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Busy scoreboard: per-register pending-write bits with flush > issue > clear
// priority and an incrementally maintained busy count.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = addr_w(NREG),
  parameter int CW   = cnt_w(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss,
  input  logic [AW-1:0]   ia,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic            flush,
  output logic [NREG-1:0] busy,
  output logic [CW-1:0]   nbusy
);

  localparam logic [AW-1:0] ZERO_A = {AW{1'b0}};

  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] busy_nxt_s;
  logic [CW-1:0]   nbusy_r;
  logic [CW-1:0]   nbusy_nxt_s;
  logic            set_s;
  logic            clr_s;

  // Next busy vector and count; set/clr only count real bit transitions
  always_comb begin
    busy_nxt_s  = busy_r;
    nbusy_nxt_s = nbusy_r;
    set_s       = 1'b0;
    clr_s       = 1'b0;
    if (flush) begin
      busy_nxt_s  = {NREG{1'b0}};
      nbusy_nxt_s = {CW{1'b0}};
    end else begin
      // A new producer to the same register supersedes the retiring one
      if (we && (wa != ZERO_A) && !(iss && (ia == wa))) begin
        clr_s          = busy_r[wa];
        busy_nxt_s[wa] = 1'b0;
      end else begin
        clr_s = 1'b0;
      end
      if (iss && (ia != ZERO_A)) begin
        set_s          = ~busy_r[ia];
        busy_nxt_s[ia] = 1'b1;
      end else begin
        set_s = 1'b0;
      end
      nbusy_nxt_s = nbusy_r + CW'(set_s) - CW'(clr_s);
    end
  end

  // Scoreboard state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r  <= {NREG{1'b0}};
      nbusy_r <= {CW{1'b0}};
    end else begin
      busy_r  <= busy_nxt_s;
      nbusy_r <= nbusy_nxt_s;
    end
  end

  assign busy  = busy_r;
  assign nbusy = nbusy_r;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with combinational read ports, optional write-to-read
// bypass and a busy scoreboard; register 0 reads zero and is never busy.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_sb_if.slave   bus
);

  localparam int AW = addr_w(NREG);
  localparam int CW = cnt_w(NREG);
  localparam logic [AW-1:0] ZERO_A = {AW{1'b0}};

  logic [XLEN-1:0] rf_r [NREG];
  logic [NREG-1:0] busy_s;

  // Writeback into the data array; address 0 is never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_r <= '{default: {XLEN{1'b0}}};
    end else if (bus.we && (bus.wa != ZERO_A)) begin
      rf_r[bus.wa] <= bus.wd;
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW),
    .CW   (CW)
  ) u_sb (
    .clk   (clk),
    .rst   (rst),
    .iss   (bus.iss),
    .ia    (bus.ia),
    .we    (bus.we),
    .wa    (bus.wa),
    .flush (bus.flush),
    .busy  (busy_s),
    .nbusy (bus.nbusy)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    localparam int RA_LO = port_lsb(i, AW);
    localparam int RD_LO = port_lsb(i, XLEN);

    logic [AW-1:0]   ra_s;
    logic            hit_s;
    logic [XLEN-1:0] rd_s;
    logic            rbusy_s;

    assign ra_s  = bus.ra[RA_LO +: AW];
    assign hit_s = (BYPASS != 0) && bus.we && (bus.wa == ra_s);

    // Read mux: x0, then same-cycle forward, then array; a forward also
    // satisfies the pending write so rbusy drops
    always_comb begin
      rd_s    = {XLEN{1'b0}};
      rbusy_s = 1'b0;
      if (ra_s == ZERO_A) begin
        rd_s    = {XLEN{1'b0}};
        rbusy_s = 1'b0;
      end else if (hit_s) begin
        rd_s    = bus.wd;
        rbusy_s = 1'b0;
      end else begin
        rd_s    = rf_r[ra_s];
        rbusy_s = busy_s[ra_s];
      end
    end

    assign bus.rd[RD_LO +: XLEN] = rd_s;
    assign bus.rbusy[i]          = rbusy_s;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized bench for regfile_sb: a BYPASS=1 and a BYPASS=0 instance share
// stimulus and are compared against an array/busy-set reference model.
module tb_regfile_sb;

  logic clk;
  logic rst;

  regfile_sb_if #(.XLEN(32), .NREG(32), .NRD(2)) bus_b ();
  regfile_sb_if #(.XLEN(32), .NREG(32), .NRD(2)) bus_n ();

  regfile_sb #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  regfile_sb #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0)) u_dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference state and the inputs currently applied
  logic [31:0] m_rf   [32];
  bit          m_busy [32];
  logic        m_we, m_iss, m_flush;
  logic [4:0]  m_wa, m_ia;
  logic [31:0] m_wd;
  logic [4:0]  m_ra   [2];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < 32; k++) begin
      m_rf[k]   = 32'h0;
      m_busy[k] = 1'b0;
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic iss, input logic [4:0] ia, input logic flush,
                       input logic [4:0] r0, input logic [4:0] r1);
    m_we = we; m_wa = wa; m_wd = wd; m_iss = iss; m_ia = ia; m_flush = flush;
    m_ra[0] = r0; m_ra[1] = r1;
    bus_b.we = we; bus_b.wa = wa; bus_b.wd = wd; bus_b.iss = iss; bus_b.ia = ia;
    bus_b.flush = flush; bus_b.ra = {r1, r0};
    bus_n.we = we; bus_n.wa = wa; bus_n.wd = wd; bus_n.iss = iss; bus_n.ia = ia;
    bus_n.flush = flush; bus_n.ra = {r1, r0};
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, r0, r1);
  endtask

  // Expected outputs follow directly from the architectural rules
  task automatic compare_model();
    int          cnt;
    logic [4:0]  a;
    logic        fwd;
    logic [31:0] e_rd;
    logic        e_rb;
    cnt = 0;
    for (int k = 0; k < 32; k++) cnt += int'(m_busy[k]);
    for (int p = 0; p < 2; p++) begin
      a = m_ra[p];
      for (int b = 0; b < 2; b++) begin
        fwd  = (b == 1) && m_we && (m_wa == a);
        e_rd = (a == 5'd0) ? 32'h0 : (fwd ? m_wd : m_rf[a]);
        e_rb = (a != 5'd0) && m_busy[a] && !fwd;
        if (b == 1) begin
          check_val("rd_byp", bus_b.rd[p*32 +: 32], e_rd);
          check_val("rbusy_byp", bus_b.rbusy[p], e_rb);
        end else begin
          check_val("rd_nobyp", bus_n.rd[p*32 +: 32], e_rd);
          check_val("rbusy_nobyp", bus_n.rbusy[p], e_rb);
        end
      end
    end
    check_val("nbusy_byp", bus_b.nbusy, cnt);
    check_val("nbusy_nobyp", bus_n.nbusy, cnt);
  endtask

  task automatic update_model();
    if (m_we && m_wa != 5'd0) m_rf[m_wa] = m_wd;
    if (m_flush) begin
      for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
    end else begin
      if (m_we && m_wa != 5'd0) m_busy[m_wa] = 1'b0;
      if (m_iss && m_ia != 5'd0) m_busy[m_ia] = 1'b1;
    end
  endtask

  task automatic tick();
    #1;
    compare_model();
    @(posedge clk);
    update_model();
    #1;
  endtask

  function automatic logic [4:0] rnd_addr();
    logic [4:0] a;
    if ($urandom_range(0, 3) == 0) a = 5'($urandom_range(0, 31));
    else a = 5'($urandom_range(0, 7));
    return a;
  endfunction

  initial begin
    rst = 1'b1;
    idle(5'd5, 5'd0);
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_nbusy", bus_b.nbusy, 64'd0);
    check_val("reset_rd", bus_b.rd, 64'd0);
    check_val("reset_rbusy", bus_b.rbusy, 64'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Async reset mid-cycle clears data, busy and count at once
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b0, 5'd5, 5'd0);
    tick();
    idle(5'd5, 5'd0);
    #1;
    check_val("pre_rst_rd", bus_n.rd[31:0], 64'hDEADBEEF);
    rst = 1'b1;
    #1;
    reset_model();
    check_val("rst_rd_byp", bus_b.rd[31:0], 64'h0);
    check_val("rst_rd_nobyp", bus_n.rd[31:0], 64'h0);
    check_val("rst_nbusy", bus_b.nbusy, 64'd0);
    check_val("rst_rbusy", bus_b.rbusy, 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    tick();

    // x0 writes and issues are discarded
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    #1;
    check_val("x0_rd_same", bus_b.rd[31:0], 64'h0);
    tick();
    idle(5'd0, 5'd0);
    #1;
    check_val("x0_rd_next", bus_b.rd[31:0], 64'h0);
    check_val("x0_nbusy", bus_b.nbusy, 64'd0);
    check_val("x0_rbusy", bus_b.rbusy, 64'd0);
    tick();

    // Bypass versus registered visibility
    drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0);
    tick();
    drive(1'b1, 5'd3, 32'h22, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0);
    #1;
    check_val("byp_rd", bus_b.rd[31:0], 64'h22);
    check_val("byp_rbusy", bus_b.rbusy[0], 64'd0);
    check_val("nobyp_rd_same", bus_n.rd[31:0], 64'h11);
    tick();
    idle(5'd3, 5'd0);
    #1;
    check_val("nobyp_rd_next", bus_n.rd[31:0], 64'h22);
    tick();

    // Issue then retire register 7
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd0);
    tick();
    idle(5'd7, 5'd0);
    #1;
    check_val("sb_rbusy_set", bus_b.rbusy[0], 64'd1);
    check_val("sb_nbusy_set", bus_b.nbusy, 64'd1);
    tick();
    drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
    #1;
    check_val("sb_wb_byp_rbusy", bus_b.rbusy[0], 64'd0);
    check_val("sb_wb_nobyp_rbusy", bus_n.rbusy[0], 64'd1);
    tick();
    idle(5'd7, 5'd0);
    #1;
    check_val("sb_rbusy_clr", bus_b.rbusy[0], 64'd0);
    check_val("sb_nbusy_clr", bus_b.nbusy, 64'd0);
    tick();

    // Issue wins over a same-address clear; different addresses net to zero
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
    tick();
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
    tick();
    idle(5'd9, 5'd0);
    #1;
    check_val("sim_rbusy9", bus_b.rbusy[0], 64'd1);
    check_val("sim_nbusy", bus_b.nbusy, 64'd1);
    tick();
    drive(1'b1, 5'd9, 32'h98, 1'b1, 5'd4, 1'b0, 5'd9, 5'd4);
    tick();
    idle(5'd9, 5'd4);
    #1;
    check_val("net_nbusy", bus_b.nbusy, 64'd1);
    check_val("net_rbusy9", bus_b.rbusy[0], 64'd0);
    check_val("net_rbusy4", bus_b.rbusy[1], 64'd1);
    tick();

    // Flush beats a concurrent issue
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0);
    tick();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(k), 1'b0, 5'd1, 5'd12);
      tick();
    end
    idle(5'd1, 5'd12);
    #1;
    check_val("fl_nbusy10", bus_b.nbusy, 64'd10);
    tick();
    drive(1'b1, 5'd2, 32'hABCD, 1'b1, 5'd12, 1'b1, 5'd12, 5'd1);
    tick();
    idle(5'd12, 5'd2);
    #1;
    check_val("fl_nbusy0", bus_b.nbusy, 64'd0);
    check_val("fl_rbusy", bus_b.rbusy, 64'd0);
    check_val("fl_wb_rd", bus_b.rd[63:32], 64'hABCD);
    tick();

    // Randomized traffic with frequent address collisions
    for (int c = 0; c < 800; c++) begin
      drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
            1'($urandom_range(0, 9) < 4), rnd_addr(),
            1'($urandom_range(0, 24) == 0), rnd_addr(), rnd_addr());
      tick();
    end
    idle(5'd0, 5'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
